// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter sharing one 4-to-16 decoder among N_REQ requesters.
// IDLE -> GRANT -> GAP cycle; the grant is held until done, owner drop, or hold limit.
module decoder_rr_arbiter #(
   parameter int N_REQ    = 16,
   parameter int ADDR_W   = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [N_REQ-1:0]  req,
   input  logic              done,
   output logic              dec_en,
   output logic [ADDR_W-1:0] dec_addr,
   output logic              busy,
   output logic              timeout
);

   localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [HW-1:0]     hold_cnt;
   logic [ADDR_W-1:0] winner;
   logic [ADDR_W-1:0] idx;
   logic              found;
   logic              rel;
   logic              lim;

   // First set request scanning from ptr upward; ADDR_W-bit math gives the wrap.
   always_comb begin
      found  = 1'b0;
      winner = ptr;
      idx    = ptr;
      for (int i = 0; i < N_REQ; i++) begin
         idx = ptr + ADDR_W'(i);
         if (!found && req[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   assign rel = done | ~req[dec_addr];
   assign lim = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         dec_en   <= 1'b0;
         dec_addr <= '0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
         ptr      <= '0;
         hold_cnt <= '0;
      end else begin
         timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  dec_addr <= winner;
                  dec_en   <= 1'b1;
                  busy     <= 1'b1;
                  hold_cnt <= HW'(1);
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (rel || lim) begin
                  dec_en  <= 1'b0;
                  ptr     <= dec_addr + ADDR_W'(1);
                  // A normal release wins over a coincident hold-limit expiry.
                  timeout <= lim & ~rel;
                  state   <= GAP;
               end else if (hold_cnt != '1) begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            GAP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter: one vector table plus hand sequences
// for wrap-around, hold-limit revoke and mid-grant reset.
module tb_decoder_rr_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] req = '0;
   logic        done = 1'b0;
   logic        dec_en;
   logic [3:0]  dec_addr;
   logic        busy;
   logic        timeout;

   int checks = 0;
   int errors = 0;

   decoder_rr_arbiter #(.N_REQ(16), .ADDR_W(4), .MAX_HOLD(8)) dut (
      .clk(clk), .reset(reset), .req(req), .done(done),
      .dec_en(dec_en), .dec_addr(dec_addr), .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] req;
      logic        done;
      logic        en;
      logic [3:0]  addr;
      logic        busy;
      logic        to;
   } vec_t;

   vec_t tbl[16];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic chk_out(input string nm, input logic en, input logic [3:0] addr,
                          input logic bs, input logic to);
      chk({nm, ".dec_en"}, 32'(dec_en), 32'(en));
      chk({nm, ".dec_addr"}, 32'(dec_addr), 32'(addr));
      chk({nm, ".busy"}, 32'(busy), 32'(bs));
      chk({nm, ".timeout"}, 32'(timeout), 32'(to));
   endtask

   // Drive inputs, take one rising edge, settle outputs away from the edge.
   task automatic step(input logic [15:0] r, input logic d);
      req  = r;
      done = d;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      req   = '0;
      done  = 1'b0;
      reset = 1'b1;
      #1;
      reset = 1'b0;
   endtask

   initial begin
      // T1 / T3 / T5(owner drop) / done outside GRANT, starting from IDLE, ptr=0
      tbl[0]  = '{16'h0001, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0};
      tbl[1]  = '{16'h0001, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0};
      tbl[2]  = '{16'h0001, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0};
      tbl[3]  = '{16'h0001, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0};
      tbl[4]  = '{16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
      tbl[5]  = '{16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
      tbl[6]  = '{16'h0010, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0};
      tbl[7]  = '{16'h0010, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0};
      tbl[8]  = '{16'h0011, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0};
      tbl[9]  = '{16'h0011, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0};
      tbl[10] = '{16'h0010, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0};
      tbl[11] = '{16'h0010, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
      tbl[12] = '{16'h0010, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0};
      tbl[13] = '{16'h0000, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0};
      tbl[14] = '{16'h0000, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0};
      tbl[15] = '{16'h0000, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0};

      // Async reset takes effect before any clock edge
      #1 reset = 1'b1;
      #1 chk_out("reset", 1'b0, 4'd0, 1'b0, 1'b0);
      #1 reset = 1'b0;

      for (int i = 0; i < 16; i++) begin
         step(tbl[i].req, tbl[i].done);
         chk_out($sformatf("vec%0d", i), tbl[i].en, tbl[i].addr, tbl[i].busy, tbl[i].to);
      end

      // T2: all requesting, done every grant -> 0..15 then wrap to 0
      do_reset();
      for (int k = 0; k < 17; k++) begin
         step(16'hFFFF, 1'b0);
         chk_out($sformatf("t2_grant%0d", k), 1'b1, 4'(k % 16), 1'b1, 1'b0);
         step(16'hFFFF, 1'b1);
         chk_out($sformatf("t2_gap%0d", k), 1'b0, 4'(k % 16), 1'b1, 1'b0);
         step(16'hFFFF, 1'b0);
         chk_out($sformatf("t2_idle%0d", k), 1'b0, 4'(k % 16), 1'b0, 1'b0);
      end

      // T4: hold limit revoke after exactly 8 enabled cycles
      do_reset();
      for (int c = 0; c < 8; c++) begin
         step(16'h0008, 1'b0);
         chk_out($sformatf("t4_hold%0d", c), 1'b1, 4'd3, 1'b1, 1'b0);
      end
      step(16'h0008, 1'b0);
      chk_out("t4_revoke", 1'b0, 4'd3, 1'b1, 1'b1);
      step(16'h0008, 1'b0);
      chk_out("t4_idle", 1'b0, 4'd3, 1'b0, 1'b0);
      step(16'h0008, 1'b0);
      chk_out("t4_regrant", 1'b1, 4'd3, 1'b1, 1'b0);

      // T5: done coincident with hold limit is a normal release
      for (int c = 0; c < 7; c++) begin
         step(16'h0008, 1'b0);
         chk_out($sformatf("t5_hold%0d", c), 1'b1, 4'd3, 1'b1, 1'b0);
      end
      step(16'h0008, 1'b1);
      chk_out("t5_done_at_lim", 1'b0, 4'd3, 1'b1, 1'b0);
      step(16'h0000, 1'b0);
      chk_out("t5_idle", 1'b0, 4'd3, 1'b0, 1'b0);

      // T6: reset between edges mid-grant, then regrant from ptr=0
      do_reset();
      step(16'h0180, 1'b0);
      chk_out("t6_grant", 1'b1, 4'd7, 1'b1, 1'b0);
      #2;
      done  = 1'b1;
      reset = 1'b1;
      #1;
      chk_out("t6_async", 1'b0, 4'd0, 1'b0, 1'b0);
      reset = 1'b0;
      step(16'h0080, 1'b0);
      chk_out("t6_regrant", 1'b1, 4'd7, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
